// File: rtl/q65_pkg.sv
// Shared definitions for the q65 register-file control path: register selects,
// sequencer state encoding and the one-hot strobe decode.
package q65_pkg;

  localparam logic [1:0] REG_A = 2'd0;
  localparam logic [1:0] REG_X = 2'd1;
  localparam logic [1:0] REG_Y = 2'd2;
  localparam logic [1:0] REG_S = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    LATCH = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4,
    SELF  = 3'd5
  } seq_state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] sel);
    onehot4 = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/q65_transfer_sequencer.sv
// Sequences source-drive and destination-load strobes for one register-to-register
// transfer on the q65 internal bus, and captures N/Z from the moved byte.
//
// state | meaning
// IDLE  | waiting for a request, reqReady high
// DRIVE | source drives the bus, bus settles before any load
// LATCH | source still driving, destination load strobe high, flags captured
// HOLD  | load dropped, source keeps driving for HOLD_CYCLES (latch hold margin)
// DONE  | strobes released, done pulse, flag write unless destination is S
// SELF  | src == dst, nothing to move, done pulse only
module q65_transfer_sequencer
  import q65_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reqValid,
  output logic       reqReady,
  input  logic [1:0] reqSrc,
  input  logic [1:0] reqDst,
  input  logic [7:0] busSample,
  output logic [3:0] enableOut,
  output logic [3:0] loadIn,
  output logic       flagsWe,
  output logic       flagN,
  output logic       flagZ,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] HOLD_LOAD = 3'(HOLD_CYCLES - 1);

  seq_state_t r_state;
  logic [1:0] r_src;
  logic [1:0] r_dst;
  logic [2:0] r_hold_cnt;
  logic [3:0] r_enable;
  logic [3:0] r_load;
  logic       r_flags_we;
  logic       r_flag_n;
  logic       r_flag_z;
  logic       r_busy;
  logic       r_done;
  logic       r_ready;

  // Outputs are registered alongside the state so each one switches on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_src      <= REG_A;
      r_dst      <= REG_A;
      r_hold_cnt <= 3'd0;
      r_enable   <= 4'b0000;
      r_load     <= 4'b0000;
      r_flags_we <= 1'b0;
      r_flag_n   <= 1'b0;
      r_flag_z   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (reqValid) begin
            r_src   <= reqSrc;
            r_dst   <= reqDst;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            if (reqSrc != reqDst) begin
              r_state  <= DRIVE;
              r_enable <= onehot4(reqSrc);
            end else begin
              r_state <= SELF;
              r_done  <= 1'b1;
            end
          end
        end
        DRIVE: begin
          r_state <= LATCH;
          r_load  <= onehot4(r_dst);
        end
        LATCH: begin
          r_state    <= HOLD;
          r_load     <= 4'b0000;
          r_hold_cnt <= HOLD_LOAD;
          r_flag_n   <= busSample[7];
          r_flag_z   <= (busSample == 8'h00);
        end
        HOLD: begin
          if (r_hold_cnt == 3'd0) begin
            r_state    <= DONE;
            r_enable   <= 4'b0000;
            r_done     <= 1'b1;
            r_flags_we <= (r_dst != REG_S);
          end else begin
            r_hold_cnt <= r_hold_cnt - 3'd1;
          end
        end
        DONE, SELF: begin
          r_state    <= IDLE;
          r_done     <= 1'b0;
          r_flags_we <= 1'b0;
          r_busy     <= 1'b0;
          r_ready    <= 1'b1;
        end
        default: begin
          r_state    <= IDLE;
          r_enable   <= 4'b0000;
          r_load     <= 4'b0000;
          r_done     <= 1'b0;
          r_flags_we <= 1'b0;
          r_busy     <= 1'b0;
          r_ready    <= 1'b1;
        end
      endcase
    end
  end

  assign reqReady  = r_ready;
  assign enableOut = r_enable;
  assign loadIn    = r_load;
  assign flagsWe   = r_flags_we;
  assign flagN     = r_flag_n;
  assign flagZ     = r_flag_z;
  assign busy      = r_busy;
  assign done      = r_done;

  // Bus-contention and latch-safety invariants
  a_enable_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(enableOut));
  a_load_onehot   : assert property (@(posedge clk) disable iff (reset) $onehot0(loadIn));
  a_load_after_drive : assert property (@(posedge clk) disable iff (reset)
    (loadIn != 4'b0000) |-> (($past(enableOut) != 4'b0000) && ($past(enableOut) == enableOut)));
  a_no_self_drive : assert property (@(posedge clk) disable iff (reset)
    ((enableOut & loadIn) == 4'b0000));

endmodule

// File: tb/tb_q65_transfer_sequencer.sv
// Directed bench for q65_transfer_sequencer: fixed transfers with hand-computed
// strobe timelines, checked cycle by cycle at the falling edge.
module tb_q65_transfer_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       reqValid, reqValid3;
  logic [1:0] reqSrc, reqDst;
  logic [7:0] busSample;

  logic       reqReady, flagsWe, flagN, flagZ, busy, done;
  logic [3:0] enableOut, loadIn;
  logic       reqReady3, flagsWe3, flagN3, flagZ3, busy3, done3;
  logic [3:0] enableOut3, loadIn3;

  int n_tests = 0;
  int n_fail  = 0;
  int n_viol  = 0;

  always #5 clk = ~clk;

  q65_transfer_sequencer #(.HOLD_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
    .reqSrc(reqSrc), .reqDst(reqDst), .busSample(busSample),
    .enableOut(enableOut), .loadIn(loadIn), .flagsWe(flagsWe),
    .flagN(flagN), .flagZ(flagZ), .busy(busy), .done(done)
  );

  q65_transfer_sequencer #(.HOLD_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .reqValid(reqValid3), .reqReady(reqReady3),
    .reqSrc(reqSrc), .reqDst(reqDst), .busSample(busSample),
    .enableOut(enableOut3), .loadIn(loadIn3), .flagsWe(flagsWe3),
    .flagN(flagN3), .flagZ(flagZ3), .busy(busy3), .done(done3)
  );

  // Independent one-hot / contention watch on both instances
  always @(negedge clk) begin
    if (!reset) begin
      if ($countones(enableOut) > 1 || $countones(loadIn) > 1 || (enableOut & loadIn) != 4'b0 ||
          $countones(enableOut3) > 1 || $countones(loadIn3) > 1 || (enableOut3 & loadIn3) != 4'b0)
        n_viol++;
    end
  end

  // Launch one request on dut: accept edge is the posedge following this call
  task automatic launch(input logic [1:0] src, input logic [1:0] dst, input logic [7:0] bus);
    @(negedge clk);
    reqSrc = src; reqDst = dst; busSample = bus; reqValid = 1'b1;
    @(posedge clk);
    #1 reqValid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #3;
    n_tests++;
    if ({enableOut, loadIn, flagsWe, flagN, flagZ, busy, done} !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b want %b", {enableOut, loadIn, flagsWe, flagN, flagZ, busy, done}, 13'b0);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (reqReady !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready got ready=%b busy=%b want ready=1 busy=0", reqReady, busy);
    end
  endtask

  // obs/exp layout: {enableOut, loadIn, done, flagsWe, reqReady, busy}
  task automatic test_tax;
    logic [11:0] exp_v[5];
    logic [11:0] obs;
    exp_v = '{{4'b0001, 4'b0000, 4'b0001}, {4'b0001, 4'b0010, 4'b0001}, {4'b0001, 4'b0000, 4'b0001},
              {4'b0000, 4'b0000, 4'b1101}, {4'b0000, 4'b0000, 4'b0010}};
    launch(2'd0, 2'd1, 8'h80);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      obs = {enableOut, loadIn, done, flagsWe, reqReady, busy};
      n_tests++;
      if (obs !== exp_v[c-1]) begin
        n_fail++;
        $display("FAIL tax_cycle%0d got %b want %b", c, obs, exp_v[c-1]);
      end
      if (c == 4) begin
        n_tests++;
        if ({flagN, flagZ} !== 2'b10) begin
          n_fail++;
          $display("FAIL tax_flags got NZ=%b want 10", {flagN, flagZ});
        end
      end
    end
  endtask

  task automatic test_txs;
    logic [11:0] exp_v[4];
    logic [11:0] obs;
    exp_v = '{{4'b0010, 4'b0000, 4'b0001}, {4'b0010, 4'b1000, 4'b0001}, {4'b0010, 4'b0000, 4'b0001},
              {4'b0000, 4'b0000, 4'b1001}};
    launch(2'd1, 2'd3, 8'h00);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      obs = {enableOut, loadIn, done, flagsWe, reqReady, busy};
      n_tests++;
      if (obs !== exp_v[c-1]) begin
        n_fail++;
        $display("FAIL txs_cycle%0d got %b want %b", c, obs, exp_v[c-1]);
      end
    end
    n_tests++;
    if ({flagN, flagZ} !== 2'b01) begin
      n_fail++;
      $display("FAIL txs_flags got NZ=%b want 01", {flagN, flagZ});
    end
    @(negedge clk);
  endtask

  // Follows TXS, so flags must stay N=0 Z=1 even though the bus shows 0x80
  task automatic test_self;
    logic [11:0] exp_v[2];
    logic [11:0] obs;
    exp_v = '{{4'b0000, 4'b0000, 4'b1001}, {4'b0000, 4'b0000, 4'b0010}};
    launch(2'd2, 2'd2, 8'h80);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      obs = {enableOut, loadIn, done, flagsWe, reqReady, busy};
      n_tests++;
      if (obs !== exp_v[c-1] || {flagN, flagZ} !== 2'b01) begin
        n_fail++;
        $display("FAIL self_cycle%0d got %b NZ=%b want %b NZ=01", c, obs, {flagN, flagZ}, exp_v[c-1]);
      end
    end
  endtask

  task automatic test_hold3;
    logic [11:0] exp_v[7];
    logic [11:0] obs;
    exp_v = '{{4'b0100, 4'b0000, 4'b0001}, {4'b0100, 4'b0001, 4'b0001}, {4'b0100, 4'b0000, 4'b0001},
              {4'b0100, 4'b0000, 4'b0001}, {4'b0100, 4'b0000, 4'b0001}, {4'b0000, 4'b0000, 4'b1101},
              {4'b0000, 4'b0000, 4'b0010}};
    @(negedge clk);
    reqSrc = 2'd2; reqDst = 2'd0; busSample = 8'h7F; reqValid3 = 1'b1;
    @(posedge clk);
    #1 reqValid3 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      obs = {enableOut3, loadIn3, done3, flagsWe3, reqReady3, busy3};
      n_tests++;
      if (obs !== exp_v[c-1]) begin
        n_fail++;
        $display("FAIL hold3_cycle%0d got %b want %b", c, obs, exp_v[c-1]);
      end
    end
    n_tests++;
    if ({flagN3, flagZ3} !== 2'b00) begin
      n_fail++;
      $display("FAIL hold3_flags got NZ=%b want 00", {flagN3, flagZ3});
    end
  endtask

  task automatic test_reset_mid;
    int spurious;
    logic [11:0] exp_v[4];
    logic [11:0] obs;
    launch(2'd0, 2'd2, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (loadIn !== 4'b0100 || enableOut !== 4'b0001) begin
      n_fail++;
      $display("FAIL tay_latch got en=%b ld=%b want en=0001 ld=0100", enableOut, loadIn);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({enableOut, loadIn, done, flagsWe, busy} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_mid_strobes got %b want %b", {enableOut, loadIn, done, flagsWe, busy}, 11'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    spurious = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || flagsWe !== 1'b0 || busy !== 1'b0) spurious++;
    end
    n_tests++;
    if (spurious != 0 || {flagN, flagZ} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_abandon got spurious=%0d NZ=%b want 0 and 00", spurious, {flagN, flagZ});
    end
    exp_v = '{{4'b0001, 4'b0000, 4'b0001}, {4'b0001, 4'b0010, 4'b0001}, {4'b0001, 4'b0000, 4'b0001},
              {4'b0000, 4'b0000, 4'b1101}};
    launch(2'd0, 2'd1, 8'h01);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      obs = {enableOut, loadIn, done, flagsWe, reqReady, busy};
      n_tests++;
      if (obs !== exp_v[c-1]) begin
        n_fail++;
        $display("FAIL post_reset_tax_cycle%0d got %b want %b", c, obs, exp_v[c-1]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [4:0] exp_ready;
    int n_done;
    exp_ready = 5'b10000;
    @(negedge clk);
    reqSrc = 2'd0; reqDst = 2'd1; busSample = 8'h42; reqValid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_tests++;
      if (reqReady !== exp_ready[c-1]) begin
        n_fail++;
        $display("FAIL b2b_ready_cycle%0d got %b want %b", c, reqReady, exp_ready[c-1]);
      end
    end
    @(negedge clk);
    reqValid = 1'b0;
    n_tests++;
    if (enableOut !== 4'b0001 || reqReady !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_accept got en=%b ready=%b want en=0001 ready=0", enableOut, reqReady);
    end
    n_done = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    n_tests++;
    if (n_done != 1 || reqReady !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_done got done_count=%0d ready=%b want 1 and 1", n_done, reqReady);
    end
  endtask

  initial begin
    reset = 1'b1; reqValid = 1'b0; reqValid3 = 1'b0;
    reqSrc = 2'd0; reqDst = 2'd0; busSample = 8'h00;
    test_reset;
    test_tax;
    test_txs;
    test_self;
    test_hold3;
    test_reset_mid;
    test_back_to_back;
    n_tests++;
    if (n_viol != 0) begin
      n_fail++;
      $display("FAIL onehot_invariant got %0d violating cycles want 0", n_viol);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
